vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Shares the single-port 1024x8 frame buffer between three users:
  - CPU port: sprite draw / read-back.
  - Scanout port: the display path that feeds the screen.
  - Internal clear engine: CLS instruction.
- Sits between the CPU core, the frame-buffer RAM and the display block.
- Sequences exactly one memory access per cycle.

Parameters:
- ADDR_W, 10, VRAM address width.
- DATA_W, 8, VRAM byte width.
- DEPTH, 1024, number of VRAM bytes swept by a clear.
- CLEAR_VALUE, 8'h00, byte written by the clear engine.

Ports:
- sys_clk  in  1  system clock; all logic rising-edge.
- sys_rst  in  1  synchronous reset, active-high.
- cpu_req  in  1  CPU access request; held until granted.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  combinational grant; access is issued this cycle.
- cpu_rvalid  out  1  read data valid, one cycle after a read grant.
- cpu_rdata  out  DATA_W  read data.
- scan_req  in  1  scanout read request; held until granted.
- scan_addr  in  ADDR_W  scanout address.
- scan_gnt  out  1  combinational grant.
- scan_rvalid  out  1  read data valid, one cycle after grant.
- scan_rdata  out  DATA_W  read data.
- cls_start  in  1  single-cycle pulse to clear VRAM.
- cls_busy  out  1  clear in progress.
- cls_done  out  1  one-cycle pulse when the clear completes.
- mem_en  out  1  RAM access enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after a read.

Behaviour:
- Reset: FSM = IDLE, clear counter = 0, RR pointer = favour scan.
  - All outputs 0: gnt, rvalid, rdata, cls_busy, cls_done, and all mem_* signals.
- FSM IDLE:
  - Only one of cpu_req / scan_req asserted -> that requester is granted.
  - Both asserted -> the RR pointer picks the winner.
  - After any grant the pointer favours the other requester.
  - Grant drives mem_en=1, mem_we (cpu_we for CPU, 0 for scan), mem_addr and mem_wdata in the same cycle.
  - No request -> mem_en=0.
- IDLE -> CLEAR on cls_start. Arbitration still operates normally in the cls_start cycle.
- FSM CLEAR:
  - cpu_gnt = scan_gnt = 0.
  - Each cycle: mem_en=1, mem_we=1, mem_addr=counter, mem_wdata=CLEAR_VALUE, then counter++.
  - cls_busy=1 for exactly DEPTH cycles.
  - After the write to DEPTH-1: return to IDLE, counter <= 0, cls_done=1 for the first IDLE cycle.
  - Arbitration resumes in that same first IDLE cycle.
- cls_start while in CLEAR is ignored; the clear does not restart.
- Read return pipeline:
  - Register a 2-bit owner tag per grant: none / cpu / scan.
  - The next cycle, the tagged port gets rvalid=1 and rdata=mem_rdata.
  - Writes and clear writes produce no rvalid.
  - rdata holds its last value when rvalid=0.
- Back-to-back grants give one rvalid per cycle.
- Read-after-write to the same address in consecutive cycles returns the new data. This relies on the RAM being write-first.
- Reset mid-clear:
  - Aborts immediately; no further writes.
  - cls_done is not pulsed.
  - VRAM contents are unspecified.
- Reset kills any pending rvalid.

Optional Feature:
- VRAM_ARB_STATS_EN defined:
  - Adds outputs stat_conflicts[15:0] and stat_stall_cycles[15:0].
  - stat_conflicts counts cycles with both requests in IDLE.
  - stat_stall_cycles counts cycles with any request asserted while in CLEAR.
  - Both counters saturate at 16'hFFFF and clear on reset.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package vram_pkg holds:
  - VRAM_ADDR_W and VRAM_DEPTH constants.
  - owner_t enum (OWN_NONE, OWN_CPU, OWN_SCAN).
  - arb_state_t enum (ST_IDLE, ST_CLEAR).
- One sub-module, vram_clear_engine, contains the counter, cls_busy and cls_done. It drives the mem_* signals when busy, selected by a mux in the arbiter.

Test Plan:
- cpu_req=1, cpu_we=0, cpu_addr=10'h005 with RAM[5]=8'hA5 -> cpu_gnt the same cycle; cpu_rvalid=1 and cpu_rdata=8'hA5 the next cycle; scan_rvalid stays 0.
- cpu_req and scan_req held for 4 cycles from reset -> grants in order scan, cpu, scan, cpu; rvalids follow one cycle later on the matching ports.
- cls_start pulse with DEPTH=1024:
  - cls_busy high for 1024 cycles; mem_addr sweeps 0..1023 with mem_wdata=8'h00.
  - cls_done pulses once afterwards; readback of addresses 0, 511 and 1023 returns 8'h00.
- cpu_req held during CLEAR -> cpu_gnt=0 throughout; granted in the cls_done cycle.
- sys_rst asserted at clear cycle 300 -> no mem_en after reset, cls_busy=0, cls_done never pulses; a new cls_start restarts from address 0.
- With VRAM_ARB_STATS_EN, 3 conflict cycles followed by 5 requesting cycles during CLEAR -> stat_conflicts=3, stat_stall_cycles=5.

Source files
------------

// File: rtl/vram_pkg.sv
// Shared constants and enums for the VRAM arbiter and its clear engine.
package vram_pkg;

    localparam int VRAM_ADDR_W = 10;
    localparam int VRAM_DEPTH  = 1024;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_SCAN = 2'd2
    } owner_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } arb_state_t;

endpackage

// File: rtl/vram_clear_engine.sv
// CLS sweep: writes CLEAR_VALUE to every VRAM address, one per cycle, while run is high.
module vram_clear_engine
    import vram_pkg::*;
#(
    parameter int                ADDR_W      = VRAM_ADDR_W,
    parameter int                DATA_W      = 8,
    parameter int                DEPTH       = VRAM_DEPTH,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic              busy,
    output logic              last,
    output logic              done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata
);

    logic [ADDR_W-1:0] cnt_p0;
    logic              done_p1;

    assign last = (cnt_p0 == ADDR_W'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_p0  <= '0;
            done_p1 <= 1'b0;
        end else begin
            // done lands in the first cycle after the final write
            done_p1 <= run && last;
            if (run) begin
                cnt_p0 <= last ? '0 : cnt_p0 + ADDR_W'(1);
            end
        end
    end

    // ---- stage p0 -> memory port ----
    assign busy      = run;
    assign done      = done_p1;
    assign mem_en    = run;
    assign mem_we    = run;
    assign mem_addr  = run ? cnt_p0 : '0;
    assign mem_wdata = run ? CLEAR_VALUE : '0;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port frame-buffer arbiter: CPU vs scanout round-robin, plus the CLS clear engine.
// Optional statistics counters are built when VRAM_ARB_STATS_EN is defined.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int                ADDR_W      = VRAM_ADDR_W,
    parameter int                DATA_W      = 8,
    parameter int                DEPTH       = VRAM_DEPTH,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              scan_req,
    input  logic [ADDR_W-1:0] scan_addr,
    output logic              scan_gnt,
    output logic              scan_rvalid,
    output logic [DATA_W-1:0] scan_rdata,
    input  logic              cls_start,
    output logic              cls_busy,
    output logic              cls_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef VRAM_ARB_STATS_EN
    ,
    output logic [15:0]       stat_conflicts,
    output logic [15:0]       stat_stall_cycles
`endif
);

    arb_state_t        state_p0, state_nxt;
    logic              fav_cpu_p0;
    owner_t            owner_p1;
    logic [DATA_W-1:0] cpu_hold_p1, scan_hold_p1;
    logic              cpu_win, scan_win, idle;

    logic              clr_busy, clr_last, clr_done, clr_en, clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] clr_wdata;

    vram_clear_engine #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .CLEAR_VALUE (CLEAR_VALUE)
    ) u_clear (
        .clk       (sys_clk),
        .rst       (sys_rst),
        .run       (state_p0 == ST_CLEAR),
        .busy      (clr_busy),
        .last      (clr_last),
        .done      (clr_done),
        .mem_en    (clr_en),
        .mem_we    (clr_we),
        .mem_addr  (clr_addr),
        .mem_wdata (clr_wdata)
    );

    // Every combinational output is forced quiet while reset is held.
    assign idle = (state_p0 == ST_IDLE) && !sys_rst;

    always_comb begin
        state_nxt = state_p0;
        cpu_win   = 1'b0;
        scan_win  = 1'b0;
        case (state_p0)
            ST_IDLE: begin
                if (cls_start) state_nxt = ST_CLEAR;
                if (idle) begin
                    if (cpu_req && scan_req) begin
                        cpu_win  = fav_cpu_p0;
                        scan_win = !fav_cpu_p0;
                    end else begin
                        cpu_win  = cpu_req;
                        scan_win = scan_req;
                    end
                end
            end
            ST_CLEAR: begin
                if (clr_last) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (clr_busy && !sys_rst) begin
            mem_en    = clr_en;
            mem_we    = clr_we;
            mem_addr  = clr_addr;
            mem_wdata = clr_wdata;
        end else if (cpu_win) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (scan_win) begin
            mem_en    = 1'b1;
            mem_addr  = scan_addr;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_p0     <= ST_IDLE;
            fav_cpu_p0   <= 1'b0;
            owner_p1     <= OWN_NONE;
            cpu_hold_p1  <= '0;
            scan_hold_p1 <= '0;
        end else begin
            state_p0 <= state_nxt;
            if (cpu_win)       fav_cpu_p0 <= 1'b0;
            else if (scan_win) fav_cpu_p0 <= 1'b1;
            if (cpu_win && !cpu_we) owner_p1 <= OWN_CPU;
            else if (scan_win)      owner_p1 <= OWN_SCAN;
            else                    owner_p1 <= OWN_NONE;
            if (cpu_rvalid)  cpu_hold_p1  <= mem_rdata;
            if (scan_rvalid) scan_hold_p1 <= mem_rdata;
        end
    end

    // ---- stage p1: read return, RAM data arrives one cycle after the grant ----
    assign cpu_gnt     = cpu_win;
    assign scan_gnt    = scan_win;
    assign cpu_rvalid  = !sys_rst && (owner_p1 == OWN_CPU);
    assign scan_rvalid = !sys_rst && (owner_p1 == OWN_SCAN);
    assign cpu_rdata   = sys_rst ? '0 : (cpu_rvalid  ? mem_rdata : cpu_hold_p1);
    assign scan_rdata  = sys_rst ? '0 : (scan_rvalid ? mem_rdata : scan_hold_p1);
    assign cls_busy    = clr_busy && !sys_rst;
    assign cls_done    = clr_done && !sys_rst;

`ifdef VRAM_ARB_STATS_EN
    logic [15:0] conf_p0, stall_p0;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            conf_p0  <= '0;
            stall_p0 <= '0;
        end else begin
            if (idle && cpu_req && scan_req && conf_p0 != 16'hFFFF)
                conf_p0 <= conf_p0 + 16'd1;
            if (state_p0 == ST_CLEAR && (cpu_req || scan_req) && stall_p0 != 16'hFFFF)
                stall_p0 <= stall_p0 + 16'd1;
        end
    end

    assign stat_conflicts    = conf_p0;
    assign stat_stall_cycles = stall_p0;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomised bench for vram_arbiter: write-first RAM model, behavioural scoreboard, directed literal checks.
module tb_vram_arbiter;

    localparam int AW = 10;
    localparam int DW = 8;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we, scan_req, cls_start;
    logic [AW-1:0] cpu_addr, scan_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt, cpu_rvalid, scan_gnt, scan_rvalid, cls_busy, cls_done;
    logic [DW-1:0] cpu_rdata, scan_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
`ifdef VRAM_ARB_STATS_EN
    logic [15:0]   stat_conflicts, stat_stall_cycles;
`endif

    int n_cmp = 0;
    int n_err = 0;

    vram_arbiter dut (
        .sys_clk     (clk),
        .sys_rst     (rst),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_gnt     (cpu_gnt),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_rdata   (cpu_rdata),
        .scan_req    (scan_req),
        .scan_addr   (scan_addr),
        .scan_gnt    (scan_gnt),
        .scan_rvalid (scan_rvalid),
        .scan_rdata  (scan_rdata),
        .cls_start   (cls_start),
        .cls_busy    (cls_busy),
        .cls_done    (cls_done),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
`ifdef VRAM_ARB_STATS_EN
        ,
        .stat_conflicts    (stat_conflicts),
        .stat_stall_cycles (stat_stall_cycles)
`endif
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write-first synchronous RAM, preloaded from init_img on the first edge.
    logic [DW-1:0] init_img [DEPTH];
    logic [DW-1:0] ram      [DEPTH];
    bit            ram_loaded = 0;

    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= init_img[i];
            ram_loaded <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr] <= mem_wdata;
                mem_rdata     <= mem_wdata;
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    // Behavioural model: what the port must show this cycle, given the rules.
    logic [DW-1:0] shadow [DEPTH];
    bit            sh_loaded = 0;
    bit            m_clearing, m_fav_scan, m_done_pend;
    int            m_idx, m_pend_own, m_conf, m_stall;
    logic [DW-1:0] m_pend_data, m_cpu_rd, m_scan_rd;
    logic          e_cg, e_sg, e_cv, e_sv, e_busy, e_done, e_en, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;

    always @(negedge clk) begin
        if (!sh_loaded) begin
            for (int i = 0; i < DEPTH; i++) shadow[i] = init_img[i];
            sh_loaded = 1;
        end
`ifdef VRAM_ARB_STATS_EN
        chk("stat_conflicts", stat_conflicts, m_conf);
        chk("stat_stall", stat_stall_cycles, m_stall);
`endif
        {e_cg, e_sg, e_cv, e_sv, e_busy, e_done, e_en, e_we} = '0;
        e_addr = '0;
        e_wd   = '0;
        if (rst) begin
            m_clearing = 0; m_fav_scan = 1; m_done_pend = 0;
            m_idx = 0; m_pend_own = 0; m_conf = 0; m_stall = 0;
            m_cpu_rd = '0; m_scan_rd = '0;
        end else begin
            e_cv = (m_pend_own == 1);
            e_sv = (m_pend_own == 2);
            if (e_cv) m_cpu_rd = m_pend_data;
            if (e_sv) m_scan_rd = m_pend_data;
            e_done = m_done_pend;
            m_done_pend = 0;
            m_pend_own = 0;
            if (m_clearing) begin
                e_busy = 1; e_en = 1; e_we = 1;
                e_addr = AW'(m_idx);
                shadow[m_idx] = 8'h00;
                if ((cpu_req || scan_req) && m_stall < 16'hFFFF) m_stall++;
                if (m_idx == DEPTH - 1) begin
                    m_clearing = 0; m_idx = 0; m_done_pend = 1;
                end else begin
                    m_idx++;
                end
            end else begin
                if (cpu_req && scan_req) begin
                    if (m_conf < 16'hFFFF) m_conf++;
                    e_sg = m_fav_scan;
                    e_cg = !m_fav_scan;
                end else begin
                    e_cg = cpu_req;
                    e_sg = scan_req;
                end
                if (e_cg) begin
                    e_en = 1; e_we = cpu_we; e_addr = cpu_addr; e_wd = cpu_wdata;
                    m_fav_scan = 1;
                    if (cpu_we) shadow[cpu_addr] = cpu_wdata;
                    else begin m_pend_own = 1; m_pend_data = shadow[cpu_addr]; end
                end else if (e_sg) begin
                    e_en = 1; e_addr = scan_addr;
                    m_fav_scan = 0;
                    m_pend_own = 2; m_pend_data = shadow[scan_addr];
                end
                if (cls_start) m_clearing = 1;
            end
        end
        chk("cpu_gnt", cpu_gnt, e_cg);
        chk("scan_gnt", scan_gnt, e_sg);
        chk("cpu_rvalid", cpu_rvalid, e_cv);
        chk("scan_rvalid", scan_rvalid, e_sv);
        chk("cpu_rdata", cpu_rdata, m_cpu_rd);
        chk("scan_rdata", scan_rdata, m_scan_rd);
        chk("cls_busy", cls_busy, e_busy);
        chk("cls_done", cls_done, e_done);
        chk("mem_en", mem_en, e_en);
        if (e_en) begin
            chk("mem_we", mem_we, e_we);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wdata", mem_wdata, e_wd);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        scan_req = 0; scan_addr = '0; cls_start = 0;
    endtask

    task automatic cpu_read_lit(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string nm);
        cpu_req = 1; cpu_we = 0; cpu_addr = a;
        #3 chk({nm, "_gnt"}, cpu_gnt, 1);
        tick();
        cpu_req = 0;
        #3 chk({nm, "_rvalid"}, cpu_rvalid, 1);
        chk({nm, "_rdata"}, cpu_rdata, exp);
        tick();
    endtask

    // Waits (bounded) for cls_done; returns busy-cycle count and sweep-order errors.
    task automatic wait_done(input string nm, output int busy_n, output int addr_bad, output int gnt_bad);
        bit seen = 0;
        busy_n = 0; addr_bad = 0; gnt_bad = 0;
        for (int c = 0; c < 1200 && !seen; c++) begin
            #3;
            if (cls_done) seen = 1;
            else begin
                if (cls_busy) begin
                    if (mem_addr !== AW'(busy_n) || mem_wdata !== 8'h00 || !mem_we) addr_bad++;
                    busy_n++;
                end
                if (cpu_gnt || scan_gnt) gnt_bad++;
                tick();
            end
        end
        chk({nm, "_done_seen"}, seen, 1);
    endtask

    initial begin
        int  bn, ab, gb, quiet_bad;
        logic cg, sg;
        for (int i = 0; i < DEPTH; i++) init_img[i] = 8'($urandom);
        init_img[5] = 8'hA5;
        rst = 1;
        quiet();
        repeat (3) tick();
        #3 chk("rst_busy", cls_busy, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_rdata", cpu_rdata, 0);
        tick();

        // single CPU read of a known byte
        rst = 0;
        cpu_read_lit(10'h005, 8'hA5, "rd5");
        chk("rd5_scan_rv", scan_rvalid, 0);

        // both requesters from reset: scan, cpu, scan, cpu
        rst = 1; tick(); tick(); rst = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'd5; scan_req = 1; scan_addr = 10'd6;
        for (int i = 0; i < 4; i++) begin
            #3 chk("rr_scan_gnt", scan_gnt, (i % 2 == 0));
            chk("rr_cpu_gnt", cpu_gnt, (i % 2 == 1));
            if (i > 0) begin
                chk("rr_cpu_rv", cpu_rvalid, (i % 2 == 0));
                chk("rr_scan_rv", scan_rvalid, (i % 2 == 1));
            end
            tick();
        end
        quiet();
        #3 chk("rr_last_cpu_rv", cpu_rvalid, 1);
        chk("rr_last_cpu_rd", cpu_rdata, 8'hA5);
        tick();

        // full clear with the CPU waiting
        cls_start = 1; tick(); cls_start = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'd9;
        wait_done("clr", bn, ab, gb);
        chk("clr_busy_cycles", bn, DEPTH);
        chk("clr_sweep_bad", ab, 0);
        chk("clr_gnt_blocked", gb, 0);
        chk("clr_gnt_on_done", cpu_gnt, 1);
        tick();
        cpu_req = 0;
        tick();
        cpu_read_lit(10'd0, 8'h00, "clr0");
        cpu_read_lit(10'd511, 8'h00, "clr511");
        cpu_read_lit(10'd1023, 8'h00, "clr1023");

        // reset in the middle of a clear, then a fresh clear
        cpu_req = 1; cpu_we = 1; cpu_addr = 10'd3; cpu_wdata = 8'h3C;
        tick();
        quiet();
        cls_start = 1; tick(); cls_start = 0;
        repeat (300) tick();
        rst = 1;
        #3 chk("abort_mem_en", mem_en, 0);
        chk("abort_busy", cls_busy, 0);
        tick();
        rst = 0;
        quiet_bad = 0;
        for (int c = 0; c < 1100; c++) begin
            #3 if (mem_en || cls_busy || cls_done) quiet_bad++;
            tick();
        end
        chk("abort_quiet", quiet_bad, 0);
        cls_start = 1; tick(); cls_start = 0;
        #3 chk("restart_addr", mem_addr, 0);
        chk("restart_en", mem_en, 1);
        wait_done("restart", bn, ab, gb);
        chk("restart_busy_cycles", bn, DEPTH);
        tick();

`ifdef VRAM_ARB_STATS_EN
        rst = 1; tick(); rst = 0;
        cpu_req = 1; scan_req = 1;
        repeat (3) tick();
        quiet();
        cls_start = 1; tick(); cls_start = 0;
        cpu_req = 1;
        repeat (5) tick();
        quiet();
        wait_done("stats", bn, ab, gb);
        tick();
        #3 chk("stat_conf_lit", stat_conflicts, 3);
        chk("stat_stall_lit", stat_stall_cycles, 5);
        tick();
`endif

        // randomised traffic with occasional clears and resets
        cg = 1; sg = 1;
        for (int c = 0; c < 5000; c++) begin
            rst = ($urandom_range(0, 1999) == 0);
            cls_start = ($urandom_range(0, 899) == 0);
            if (!cpu_req || cg) begin
                cpu_req = ($urandom_range(0, 9) < 6);
                cpu_we = $urandom_range(0, 1);
                cpu_addr = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 15)) : AW'($urandom);
                cpu_wdata = 8'($urandom);
            end
            if (!scan_req || sg) begin
                scan_req = ($urandom_range(0, 9) < 5);
                scan_addr = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 15)) : AW'($urandom);
            end
            #3 cg = cpu_gnt; sg = scan_gnt;
            tick();
        end
        rst = 0;
        quiet();
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
